// File: rtl/cpu_clken_sequencer_pkg.sv
// Shared definitions for the CPU clock-enable sequencer: PLL reconfiguration FSM
// encoding and the width/period helpers used to size the divider and counters.
package cpu_clken_sequencer_pkg;

    typedef enum logic [1:0] {
        PLL_IDLE     = 2'd0,
        PLL_SETTLE   = 2'd1,
        PLL_STEP     = 2'd2,
        PLL_WAIT_RDY = 2'd3
    } pll_fsm_e;

    localparam int PLL_CFG_W = 3;

    function automatic int sw_width(input int nspeeds);
        return (nspeeds > 1) ? $clog2(nspeeds) : 1;
    endfunction

    function automatic int cnt_width(input int nspeeds);
        return (nspeeds > 2) ? nspeeds - 1 : 1;
    endfunction

    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Speed 0 is the slowest: period halves with each speed step (4 speeds -> 8,4,2,1).
    function automatic int period_of(input int nspeeds, input int speed);
        return 1 << (nspeeds - 1 - speed);
    endfunction

    function automatic int clamp_speed(input int sel, input int nspeeds);
        return (sel >= nspeeds) ? nspeeds - 1 : sel;
    endfunction

endpackage

// File: rtl/cpu_clken_sequencer_if.sv
// Bundle of the speed/contention/PLL controls and the CPU enable outputs.
// The sequencer is the slave; whatever drives turbo/ULA/PLL inputs is the master.
interface cpu_clken_sequencer_if #(
    parameter int SW = 2
);
    logic [SW-1:0] turbo_sel;
    logic          cpu_contention;
    logic [2:0]    pll_option;
    logic          pll_ready;
    logic          cpu_clken;
    logic          cpu_phase;
    logic [SW-1:0] speed_active;
    logic          pll_sstep;
    logic [2:0]    pll_state;
    logic          pll_busy;
    logic          pll_err;

    modport master (
        output turbo_sel, cpu_contention, pll_option, pll_ready,
        input  cpu_clken, cpu_phase, speed_active, pll_sstep, pll_state, pll_busy, pll_err
    );

    modport slave (
        input  turbo_sel, cpu_contention, pll_option, pll_ready,
        output cpu_clken, cpu_phase, speed_active, pll_sstep, pll_state, pll_busy, pll_err
    );
endinterface

// File: rtl/cpu_clken_sequencer_pll_reconf_sequencer.sv
// PLL reconfiguration sequencer: waits for a stable option, issues a one-cycle
// step pulse, then waits for ready (or times out) while holding the CPU busy.
module cpu_clken_sequencer_pll_reconf_sequencer
    import cpu_clken_sequencer_pkg::*;
#(
    parameter int SETTLE      = 8,
    parameter int RDY_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PLL_CFG_W-1:0] i_option,
    input  logic                 i_ready,
    output logic                 o_sstep,
    output logic [PLL_CFG_W-1:0] o_state,
    output logic                 o_busy,
    output logic                 o_err
);
    localparam int STW = ctr_width(SETTLE);
    localparam int TOW = ctr_width(RDY_TIMEOUT);
    localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE - 1);
    localparam logic [TOW-1:0] TMO_LAST    = TOW'(RDY_TIMEOUT - 1);

    pll_fsm_e             r_fsm, w_fsm_nxt;
    logic [STW-1:0]       r_settle, w_settle_nxt;
    logic [TOW-1:0]       r_tmo, w_tmo_nxt;
    logic [PLL_CFG_W-1:0] r_opt, r_cfg, w_cfg_nxt;
    logic                 r_sstep, r_busy, r_err, w_err_nxt;

    // Reset lands in SETTLE so every boot performs a configuration pass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm    <= PLL_SETTLE;
            r_settle <= '0;
            r_tmo    <= '0;
            r_opt    <= '0;
            r_cfg    <= '0;
            r_sstep  <= 1'b0;
            r_busy   <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            r_fsm    <= w_fsm_nxt;
            r_settle <= w_settle_nxt;
            r_tmo    <= w_tmo_nxt;
            r_opt    <= i_option;
            r_cfg    <= w_cfg_nxt;
            r_sstep  <= (w_fsm_nxt == PLL_STEP);
            r_busy   <= (w_fsm_nxt != PLL_IDLE);
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt    = r_fsm;
        w_settle_nxt = r_settle;
        w_tmo_nxt    = r_tmo;
        w_cfg_nxt    = r_cfg;
        w_err_nxt    = r_err;
        case (r_fsm)
            PLL_IDLE: begin
                // Comparing against the applied config catches changes made mid-step.
                if (i_option != r_cfg) begin
                    w_fsm_nxt    = PLL_SETTLE;
                    w_settle_nxt = '0;
                end
            end
            PLL_SETTLE: begin
                if (i_option != r_opt) begin
                    w_settle_nxt = '0;
                end else if (r_settle == SETTLE_LAST) begin
                    w_fsm_nxt = PLL_STEP;
                    w_cfg_nxt = i_option;
                end else begin
                    w_settle_nxt = r_settle + 1'b1;
                end
            end
            PLL_STEP: begin
                w_fsm_nxt = PLL_WAIT_RDY;
                w_tmo_nxt = '0;
            end
            PLL_WAIT_RDY: begin
                if (i_ready) begin
                    w_fsm_nxt = PLL_IDLE;
                end else if (r_tmo == TMO_LAST) begin
                    w_fsm_nxt = PLL_IDLE;
                    w_err_nxt = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            default: w_fsm_nxt = PLL_IDLE;
        endcase
    end

    assign o_sstep = r_sstep;
    assign o_state = r_cfg;
    assign o_busy  = r_busy;
    assign o_err   = r_err;

endmodule

// File: rtl/cpu_clken_sequencer.sv
// Single-clock CPU enable generator: divides the master clock by a selectable
// power of two, stalls on contention or PLL reconfiguration, switches speed at period edges.
module cpu_clken_sequencer
    import cpu_clken_sequencer_pkg::*;
#(
    parameter int NSPEEDS     = 4,
    parameter int SETTLE      = 8,
    parameter int RDY_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_clken_sequencer_if.slave bus
);
    localparam int SW = sw_width(NSPEEDS);
    localparam int CW = cnt_width(NSPEEDS);

    logic [SW-1:0] r_speed, w_sel, w_speed_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_last, w_last_nxt;
    logic          r_clken, r_phase, w_phase_nxt;
    logic          w_stall, w_term, w_fire, w_pll_busy;

    function automatic logic [CW-1:0] last_cnt(input logic [SW-1:0] s);
        return CW'(period_of(NSPEEDS, int'(s)) - 1);
    endfunction

    always_comb begin
        w_sel       = SW'(clamp_speed(int'(bus.turbo_sel), NSPEEDS));
        w_last      = last_cnt(r_speed);
        w_term      = (r_cnt == w_last);
        w_stall     = bus.cpu_contention | w_pll_busy;
        w_fire      = w_term & ~w_stall;
        w_speed_nxt = r_speed;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (w_fire) begin
            w_speed_nxt = w_sel;
            w_cnt_nxt   = '0;
        end else if (w_term) begin
            // Parked at terminal count: adopt the new speed but stay ready to fire on release.
            w_speed_nxt = w_sel;
            w_cnt_nxt   = last_cnt(w_sel);
        end
        w_last_nxt = last_cnt(w_speed_nxt);
        if (w_last_nxt == '0) begin
            w_phase_nxt = w_fire ? ~r_phase : r_phase;
        end else begin
            w_phase_nxt = (w_cnt_nxt <= (w_last_nxt >> 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_speed <= '0;
            r_clken <= 1'b0;
            r_phase <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_speed <= w_speed_nxt;
            r_clken <= w_fire;
            r_phase <= w_phase_nxt;
        end
    end

    cpu_clken_sequencer_pll_reconf_sequencer #(
        .SETTLE      (SETTLE),
        .RDY_TIMEOUT (RDY_TIMEOUT)
    ) u_pll (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_option (bus.pll_option),
        .i_ready  (bus.pll_ready),
        .o_sstep  (bus.pll_sstep),
        .o_state  (bus.pll_state),
        .o_busy   (w_pll_busy),
        .o_err    (bus.pll_err)
    );

    assign bus.pll_busy     = w_pll_busy;
    assign bus.cpu_clken    = r_clken;
    assign bus.cpu_phase    = r_phase;
    assign bus.speed_active = r_speed;

endmodule
